// File: rtl/enc8b10b_pkg.sv
// Shared 8b/10b definitions: sync states, comma symbols, RD encoding and the
// 6b sub-block decode result.
package enc8b10b_pkg;

    typedef enum logic [1:0] {LOSS, ACQ, SYNC} sync_state_t;

    localparam logic [9:0] K28_5_RDN = 10'h0FA;
    localparam logic [9:0] K28_5_RDP = 10'h305;

    localparam logic RD_NEG = 1'b0;
    localparam logic RD_POS = 1'b1;

    // set_p/set_n give the RD a sub-block forces; unbal marks a +-2 sub-block
    typedef struct packed {
        logic [4:0] dat;
        logic       valid;
        logic       k28;
        logic       unbal;
        logic       set_p;
        logic       set_n;
    } dec6_t;

    function automatic logic [2:0] ones4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

endpackage

// File: rtl/decoder_6b5b.sv
// Combinational 6b->5b lookup with validity, K28 marker and disparity class.
module decoder_6b5b
    import enc8b10b_pkg::*;
(
    input  logic [5:0] code6,
    output dec6_t      res
);

    logic [2:0] ones;

    always_comb begin
        ones = 3'd0;
        for (int i = 0; i < 6; i++) ones = ones + {2'b00, code6[i]};
    end

    always_comb begin
        res       = '0;
        res.valid = 1'b1;
        res.unbal = (ones != 3'd3);
        res.set_p = (ones > 3'd3) || (code6 == 6'b000111);
        res.set_n = (ones < 3'd3) || (code6 == 6'b111000);
        case (code6)
            6'b100111, 6'b011000: res.dat = 5'd0;
            6'b011101, 6'b100010: res.dat = 5'd1;
            6'b101101, 6'b010010: res.dat = 5'd2;
            6'b110001:            res.dat = 5'd3;
            6'b110101, 6'b001010: res.dat = 5'd4;
            6'b101001:            res.dat = 5'd5;
            6'b011001:            res.dat = 5'd6;
            6'b111000, 6'b000111: res.dat = 5'd7;
            6'b111001, 6'b000110: res.dat = 5'd8;
            6'b100101:            res.dat = 5'd9;
            6'b010101:            res.dat = 5'd10;
            6'b110100:            res.dat = 5'd11;
            6'b001101:            res.dat = 5'd12;
            6'b101100:            res.dat = 5'd13;
            6'b011100:            res.dat = 5'd14;
            6'b010111, 6'b101000: res.dat = 5'd15;
            6'b011011, 6'b100100: res.dat = 5'd16;
            6'b100011:            res.dat = 5'd17;
            6'b010011:            res.dat = 5'd18;
            6'b110010:            res.dat = 5'd19;
            6'b001011:            res.dat = 5'd20;
            6'b101010:            res.dat = 5'd21;
            6'b011010:            res.dat = 5'd22;
            6'b111010, 6'b000101: res.dat = 5'd23;
            6'b110011, 6'b001100: res.dat = 5'd24;
            6'b100110:            res.dat = 5'd25;
            6'b010110:            res.dat = 5'd26;
            6'b110110, 6'b001001: res.dat = 5'd27;
            6'b001110:            res.dat = 5'd28;
            6'b101110, 6'b010001: res.dat = 5'd29;
            6'b011110, 6'b100001: res.dat = 5'd30;
            6'b101011, 6'b010100: res.dat = 5'd31;
            6'b001111, 6'b110000: begin
                res.dat = 5'd28;
                res.k28 = 1'b1;
            end
            default: res.valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/decoder_8b10b.sv
// 8b/10b receive decoder: 4b lookup, running disparity, error flags and the
// comma-based sync state machine.
module decoder_8b10b
    import enc8b10b_pkg::*;
#(
    parameter int SYNC_COMMAS = 3,
    parameter int ERR_LIMIT   = 4,
    parameter int GOOD_RUN    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid_in,
    input  logic [9:0] data_in,
    output logic       valid_out,
    output logic [7:0] data_out,
    output logic       k_out,
    output logic       code_err,
    output logic       disp_err,
    output logic       rd_out,
    output logic       sync
);

    localparam int CW = $clog2(SYNC_COMMAS + 1);
    localparam int EW = $clog2(ERR_LIMIT + 1);
    localparam int GW = $clog2(GOOD_RUN + 1);
    localparam logic [CW-1:0] COMMA_TGT = CW'(SYNC_COMMAS);
    localparam logic [EW-1:0] ERR_TGT   = EW'(ERR_LIMIT);
    localparam logic [GW-1:0] GOOD_LAST = GW'(GOOD_RUN - 1);

    sync_state_t   state, state_n;
    logic [CW-1:0] comma_cnt, comma_cnt_n;
    logic [EW-1:0] err_cnt, err_cnt_n;
    logic [GW-1:0] good_cnt, good_cnt_n;

    dec6_t      d6;
    logic [3:0] f4, f4_lu;
    logic [2:0] d3, ones_f4;
    logic       d4_ok, a7, k7, a7_ok, k28_ok;
    logic       pos4, neg4, unbal4, rd_mid, rd_fin, rd_n;
    logic       code_n, disp_n, k_n, err, comma;

    decoder_6b5b u_dec6 (.code6(data_in[9:4]), .res(d6));

    // K28 at RD+ sends the 4b sub-block inverted, so undo that before lookup
    assign f4    = data_in[3:0];
    assign f4_lu = (d6.k28 && data_in[9:4] == 6'b110000) ? ~f4 : f4;

    always_comb begin
        d3    = 3'd0;
        d4_ok = 1'b1;
        a7    = 1'b0;
        case (f4_lu)
            4'b1011, 4'b0100: d3 = 3'd0;
            4'b1001:          d3 = 3'd1;
            4'b0101:          d3 = 3'd2;
            4'b1100, 4'b0011: d3 = 3'd3;
            4'b1101, 4'b0010: d3 = 3'd4;
            4'b1010:          d3 = 3'd5;
            4'b0110:          d3 = 3'd6;
            4'b1110, 4'b0001: d3 = 3'd7;
            4'b0111, 4'b1000: begin
                d3 = 3'd7;
                a7 = 1'b1;
            end
            default: d4_ok = 1'b0;
        endcase
    end

    assign k28_ok = f4_lu inside {4'b0100, 4'b1001, 4'b0101, 4'b0011,
                                  4'b0010, 4'b1010, 4'b0110, 4'b1000};
    assign k7     = d6.dat inside {5'd23, 5'd27, 5'd29, 5'd30};
    assign a7_ok  = (d6.dat inside {5'd17, 5'd18, 5'd20} && f4 == 4'b0111) ||
                    (d6.dat inside {5'd11, 5'd13, 5'd14} && f4 == 4'b1000);

    assign code_n = !d6.valid || !d4_ok ||
                    (d6.k28 ? !k28_ok : (a7 && !k7 && !a7_ok));
    assign k_n    = !code_n && (d6.k28 || (a7 && k7));

    assign ones_f4 = ones4(f4);
    assign pos4    = (ones_f4 > 3'd2) || (f4 == 4'b0011);
    assign neg4    = (ones_f4 < 3'd2) || (f4 == 4'b1100);
    assign unbal4  = (ones_f4 != 3'd2);

    assign rd_mid = d6.set_p ? RD_POS : (d6.set_n ? RD_NEG : rd_out);
    assign rd_fin = pos4 ? RD_POS : (neg4 ? RD_NEG : rd_mid);
    assign disp_n = !code_n && ((d6.unbal && (d6.set_p == rd_out)) ||
                                (unbal4 && (pos4 == rd_mid)));
    assign rd_n   = code_n ? rd_out : rd_fin;

    assign err   = code_n || disp_n;
    assign comma = !err && (data_in == K28_5_RDN || data_in == K28_5_RDP);

    always_comb begin
        state_n     = state;
        comma_cnt_n = comma_cnt;
        err_cnt_n   = err_cnt;
        good_cnt_n  = good_cnt;
        if (valid_in) begin
            case (state)
                LOSS: if (comma) begin
                    if (COMMA_TGT == CW'(1)) begin
                        state_n    = SYNC;
                        err_cnt_n  = '0;
                        good_cnt_n = '0;
                    end else begin
                        state_n     = ACQ;
                        comma_cnt_n = CW'(1);
                    end
                end
                ACQ: begin
                    if (!comma) begin
                        state_n     = LOSS;
                        comma_cnt_n = '0;
                    end else if (comma_cnt + 1'b1 == COMMA_TGT) begin
                        state_n     = SYNC;
                        comma_cnt_n = '0;
                        err_cnt_n   = '0;
                        good_cnt_n  = '0;
                    end else begin
                        comma_cnt_n = comma_cnt + 1'b1;
                    end
                end
                SYNC: begin
                    if (err) begin
                        good_cnt_n = '0;
                        if (err_cnt + 1'b1 == ERR_TGT) begin
                            state_n   = LOSS;
                            err_cnt_n = '0;
                        end else begin
                            err_cnt_n = err_cnt + 1'b1;
                        end
                    end else if (good_cnt == GOOD_LAST) begin
                        good_cnt_n = '0;
                        if (err_cnt != '0) err_cnt_n = err_cnt - 1'b1;
                    end else begin
                        good_cnt_n = good_cnt + 1'b1;
                    end
                end
                default: state_n = LOSS;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOSS;
            comma_cnt <= '0;
            err_cnt   <= '0;
            good_cnt  <= '0;
            valid_out <= 1'b0;
            data_out  <= 8'h00;
            k_out     <= 1'b0;
            code_err  <= 1'b0;
            disp_err  <= 1'b0;
            rd_out    <= RD_NEG;
        end else begin
            state     <= state_n;
            comma_cnt <= comma_cnt_n;
            err_cnt   <= err_cnt_n;
            good_cnt  <= good_cnt_n;
            valid_out <= valid_in;
            if (valid_in) begin
                data_out <= {d3, d6.dat};
                k_out    <= k_n;
                code_err <= code_n;
                disp_err <= disp_n;
                rd_out   <= rd_n;
            end
        end
    end

    assign sync = (state == SYNC);

endmodule

// File: tb/tb_decoder_8b10b.sv
// Directed bench for decoder_8b10b: comma sync, data decode, valid gaps,
// code/disparity errors, good-run error decay and async reset.
module tb_decoder_8b10b;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid_in = 1'b0;
    logic [9:0] data_in = 10'h000;
    logic       valid_out, k_out, code_err, disp_err, rd_out, sync;
    logic [7:0] data_out;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    decoder_8b10b dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in),
        .valid_out(valid_out), .data_out(data_out), .k_out(k_out),
        .code_err(code_err), .disp_err(disp_err), .rd_out(rd_out), .sync(sync)
    );

    task automatic sym(input logic [9:0] s);
        @(negedge clk);
        valid_in = 1'b1;
        data_in  = s;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        valid_in = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        valid_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({valid_out, data_out, k_out, code_err, disp_err, rd_out, sync} !== 14'h0) begin
            miscompares++;
            $display("FAIL reset_values: got %b want all zero",
                     {valid_out, data_out, k_out, code_err, disp_err, rd_out, sync});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_comma_sync();
        logic [9:0] seq [3] = '{10'h0FA, 10'h305, 10'h0FA};
        logic       rd_e [3] = '{1'b1, 1'b0, 1'b1};
        logic       sy_e [3] = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            sym(seq[i]);
            vectors++;
            if ({valid_out, k_out, code_err, disp_err, data_out} !== {4'b1100, 8'hBC}) begin
                miscompares++;
                $display("FAIL comma[%0d] v/k/ce/de/data: got %b %b %b %b %h want 1 1 0 0 bc",
                         i, valid_out, k_out, code_err, disp_err, data_out);
            end
            vectors++;
            if (rd_out !== rd_e[i]) begin
                miscompares++;
                $display("FAIL comma[%0d] rd: got %b want %b", i, rd_out, rd_e[i]);
            end
            vectors++;
            if (sync !== sy_e[i]) begin
                miscompares++;
                $display("FAIL comma[%0d] sync: got %b want %b", i, sync, sy_e[i]);
            end
        end
    endtask

    task automatic test_data();
        logic [9:0] seq [5] = '{10'h305, 10'h274, 10'h2AA, 10'h3A8, 10'h237};
        logic [7:0] dat_e [5] = '{8'hBC, 8'h00, 8'hB5, 8'hF7, 8'hF1};
        logic       k_e [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic       rd_e [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            sym(seq[i]);
            vectors++;
            if (data_out !== dat_e[i] || k_out !== k_e[i]) begin
                miscompares++;
                $display("FAIL data[%0d] data/k: got %h %b want %h %b",
                         i, data_out, k_out, dat_e[i], k_e[i]);
            end
            vectors++;
            if ({code_err, disp_err, rd_out, sync} !== {2'b00, rd_e[i], 1'b1}) begin
                miscompares++;
                $display("FAIL data[%0d] ce/de/rd/sync: got %b %b %b %b want 0 0 %b 1",
                         i, code_err, disp_err, rd_out, sync, rd_e[i]);
            end
        end
    endtask

    task automatic test_valid_gap();
        for (int i = 0; i < 5; i++) begin
            idle();
            vectors++;
            if ({valid_out, data_out, k_out, rd_out, sync} !== {1'b0, 8'hF1, 1'b0, 1'b1, 1'b1}) begin
                miscompares++;
                $display("FAIL gap[%0d] v/data/k/rd/sync: got %b %h %b %b %b want 0 f1 0 1 1",
                         i, valid_out, data_out, k_out, rd_out, sync);
            end
        end
        sym(10'h2AA);
        vectors++;
        if ({valid_out, data_out, rd_out} !== {1'b1, 8'hB5, 1'b1}) begin
            miscompares++;
            $display("FAIL gap_resume v/data/rd: got %b %h %b want 1 b5 1",
                     valid_out, data_out, rd_out);
        end
    endtask

    task automatic test_code_err();
        for (int i = 0; i < 4; i++) begin
            sym(10'h000);
            vectors++;
            if ({code_err, disp_err, k_out, rd_out} !== 4'b1001) begin
                miscompares++;
                $display("FAIL code_err[%0d] ce/de/k/rd: got %b %b %b %b want 1 0 0 1",
                         i, code_err, disp_err, k_out, rd_out);
            end
            vectors++;
            if (sync !== (i < 3)) begin
                miscompares++;
                $display("FAIL code_err[%0d] sync: got %b want %b", i, sync, i < 3);
            end
        end
    endtask

    task automatic test_resync();
        logic [9:0] seq [3] = '{10'h305, 10'h0FA, 10'h305};
        logic       rd_e [3] = '{1'b0, 1'b1, 1'b0};
        logic       sy_e [3] = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            sym(seq[i]);
            vectors++;
            if ({disp_err, rd_out, sync} !== {1'b0, rd_e[i], sy_e[i]}) begin
                miscompares++;
                $display("FAIL resync[%0d] de/rd/sync: got %b %b %b want 0 %b %b",
                         i, disp_err, rd_out, sync, rd_e[i], sy_e[i]);
            end
        end
    endtask

    task automatic test_good_run();
        sym(10'h000);
        repeat (16) sym(10'h2AA);
        for (int i = 0; i < 3; i++) begin
            sym(10'h000);
            vectors++;
            if (sync !== 1'b1) begin
                miscompares++;
                $display("FAIL good_run_decay[%0d] sync: got %b want 1", i, sync);
            end
        end
        sym(10'h237);
        vectors++;
        if ({rd_out, code_err, disp_err, data_out} !== {3'b100, 8'hF1}) begin
            miscompares++;
            $display("FAIL good_run_a7 rd/ce/de/data: got %b %b %b %h want 1 0 0 f1",
                     rd_out, code_err, disp_err, data_out);
        end
        repeat (14) sym(10'h2AA);
        sym(10'h000);
        vectors++;
        if ({sync, code_err, rd_out} !== 3'b011) begin
            miscompares++;
            $display("FAIL good_run_short sync/ce/rd: got %b %b %b want 0 1 1",
                     sync, code_err, rd_out);
        end
    endtask

    task automatic test_reset_mid_acq();
        sym(10'h305);
        sym(10'h0FA);
        vectors++;
        if ({rd_out, sync, data_out} !== {2'b10, 8'hBC}) begin
            miscompares++;
            $display("FAIL acq_pre rd/sync/data: got %b %b %h want 1 0 bc", rd_out, sync, data_out);
        end
        valid_in = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({valid_out, data_out, k_out, code_err, disp_err, rd_out, sync} !== 14'h0) begin
            miscompares++;
            $display("FAIL async_reset: got %b want all zero",
                     {valid_out, data_out, k_out, code_err, disp_err, rd_out, sync});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sym(i == 1 ? 10'h305 : 10'h0FA);
            vectors++;
            if ({disp_err, rd_out, sync} !== {1'b0, i != 1, i == 2}) begin
                miscompares++;
                $display("FAIL post_reset[%0d] de/rd/sync: got %b %b %b want 0 %b %b",
                         i, disp_err, rd_out, sync, i != 1, i == 2);
            end
        end
    endtask

    task automatic test_disp_err();
        @(negedge clk);
        valid_in = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sym(10'h305);
        vectors++;
        if ({disp_err, code_err, k_out, data_out} !== {3'b101, 8'hBC}) begin
            miscompares++;
            $display("FAIL disp_err de/ce/k/data: got %b %b %b %h want 1 0 1 bc",
                     disp_err, code_err, k_out, data_out);
        end
        vectors++;
        if ({rd_out, sync} !== 2'b00) begin
            miscompares++;
            $display("FAIL disp_err rd/sync: got %b %b want 0 0", rd_out, sync);
        end
        sym(10'h0FA);
        sym(10'h305);
        vectors++;
        if (sync !== 1'b0) begin
            miscompares++;
            $display("FAIL disp_no_acq sync after 2 commas: got %b want 0", sync);
        end
        sym(10'h0FA);
        vectors++;
        if ({sync, rd_out} !== 2'b11) begin
            miscompares++;
            $display("FAIL disp_acq sync/rd after 3 commas: got %b %b want 1 1", sync, rd_out);
        end
    endtask

    initial begin
        test_reset();
        test_comma_sync();
        test_data();
        test_valid_gap();
        test_code_err();
        test_resync();
        test_good_run();
        test_reset_mid_acq();
        test_disp_err();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
